// File: rtl/ising_anneal_ctrl.sv
// ising_anneal_ctrl: coupling-weight register file and anneal sequencer for an N-spin oscillator Ising array.
// Build macro ISING_ENERGY_EN adds a registered signed energy output for the resolved spin vector.
module ising_anneal_ctrl #(
   parameter int N             = 3,
   parameter int WW            = 3,
   parameter int WMID          = 2,
   parameter int LOAD_CYCLES   = 16,
   parameter int SAMPLE_CYCLES = 64,
   parameter int CW            = 32,
   localparam int NP = N * (N - 1) / 2,
   localparam int AW = (NP > 1) ? $clog2(NP) : 1,
   localparam int SW = $clog2(SAMPLE_CYCLES + 1),
   localparam int EW = WW + $clog2(N * N) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [AW-1:0]      cfg_addr,
   input  logic [WW-1:0]      cfg_wdata,
   input  logic [N-1:0]       init_spin,
   input  logic [CW-1:0]      run_cycles,
   input  logic               start,
   input  logic [N-1:0]       osc_in,
   output logic               array_rstn,
   output logic [N-1:0]       array_init,
   output logic [WW*NP-1:0]   weights,
   output logic               busy,
   output logic               done,
   output logic [N-1:0]       spin_out,
   output logic [SW*N-1:0]    agree_cnt
`ifdef ISING_ENERGY_EN
   ,
   output logic signed [EW-1:0] energy
`endif
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_RUN     = 3'd2;
   localparam logic [2:0] S_SAMPLE  = 3'd3;
   localparam logic [2:0] S_RESOLVE = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   localparam logic [CW-1:0] LOAD_LAST   = CW'(LOAD_CYCLES - 1);
   localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);

   logic [2:0]      state;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   run_len;
   logic [N-1:0]    osc_p0;
   logic [N-1:0]    osc_p1;
   logic [SW*N-1:0] acc;
   logic            wr_ok;

   // Spin i is 0 when it spent a strict majority of the window in phase with spin 0.
   function automatic logic [N-1:0] resolve_spins(input logic [SW*N-1:0] a);
      logic [N-1:0] s;
      s = '0;
      for (int i = 1; i < N; i++)
         s[i] = (a[i*SW +: SW] > SW'(SAMPLE_CYCLES / 2)) ? 1'b0 : 1'b1;
      return s;
   endfunction

`ifdef ISING_ENERGY_EN
   function automatic logic signed [EW-1:0] calc_energy(input logic [WW*NP-1:0] w,
                                                         input logic [N-1:0]     s);
      logic signed [EW-1:0] e;
      logic signed [EW-1:0] j;
      int p;
      e = '0;
      p = 0;
      for (int i = 0; i < N; i++) begin
         for (int k = i + 1; k < N; k++) begin
            j = EW'(signed'({1'b0, w[p*WW +: WW]})) - EW'(WMID);
            // E = -sum J*si*sj; equal spin bits give si*sj = +1
            e = (s[i] == s[k]) ? (e - j) : (e + j);
            p++;
         end
      end
      return e;
   endfunction
`endif

   assign array_rstn = (state == S_RUN) || (state == S_SAMPLE) ||
                       (state == S_RESOLVE) || (state == S_DONE);
   assign busy       = (state != S_IDLE);
   assign done       = (state == S_DONE);
   assign wr_ok      = (state == S_IDLE) && cfg_we &&
                       ({{(32-AW){1'b0}}, cfg_addr} < 32'(NP));

   // Two-flop synchronizer stage boundary for the free-running oscillators
   always_ff @(posedge clk) begin
      if (rst) begin
         osc_p0 <= '0;
         osc_p1 <= '0;
      end else begin
         osc_p0 <= osc_in;
         osc_p1 <= osc_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         weights <= {NP{WW'(WMID)}};
      end else if (wr_ok) begin
         weights[cfg_addr*WW +: WW] <= cfg_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         run_len    <= '0;
         array_init <= '0;
         acc        <= '0;
         spin_out   <= '0;
         agree_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_LOAD;
                  cnt        <= '0;
                  acc        <= '0;
                  array_init <= init_spin;
                  run_len    <= (run_cycles == '0) ? CW'(1) : run_cycles;
               end
            end
            S_LOAD: begin
               if (cnt == LOAD_LAST) begin
                  state <= S_RUN;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_RUN: begin
               if (cnt == run_len - CW'(1)) begin
                  state <= S_SAMPLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_SAMPLE: begin
               for (int i = 0; i < N; i++)
                  if (osc_p1[i] == osc_p1[0])
                     acc[i*SW +: SW] <= acc[i*SW +: SW] + SW'(1);
               if (cnt == SAMPLE_LAST) begin
                  state <= S_RESOLVE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_RESOLVE: begin
               agree_cnt <= acc;
               spin_out  <= resolve_spins(acc);
               state     <= S_DONE;
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef ISING_ENERGY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         energy <= '0;
      end else if (state == S_DONE) begin
         energy <= calc_energy(weights, spin_out);
      end
   end
`endif

endmodule

// File: tb/tb_ising_anneal_ctrl.sv
// Self-checking bench for ising_anneal_ctrl: scoreboard of expected run results popped on done.
module tb_ising_anneal_ctrl;

   logic        clk;
   logic        rst;
   logic        cfg_we;
   logic [1:0]  cfg_addr;
   logic [2:0]  cfg_wdata;
   logic [2:0]  init_spin;
   logic [31:0] run_cycles;
   logic        start;
   logic [2:0]  osc_in;
   logic        array_rstn;
   logic [2:0]  array_init;
   logic [8:0]  weights;
   logic        busy;
   logic        done;
   logic [2:0]  spin_out;
   logic [20:0] agree_cnt;
`ifdef ISING_ENERGY_EN
   logic [7:0]  energy;
`endif

   typedef struct {
      int          lat;
      logic [2:0]  spin;
      logic [20:0] agree;
      logic [7:0]  energy;
   } exp_t;

   exp_t       sb[$];
   logic [2:0] wmodel[3];
   int         osc_mode;
   int         n_checks;
   int         n_err;

   ising_anneal_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .init_spin  (init_spin),
      .run_cycles (run_cycles),
      .start      (start),
      .osc_in     (osc_in),
      .array_rstn (array_rstn),
      .array_init (array_init),
      .weights    (weights),
      .busy       (busy),
      .done       (done),
      .spin_out   (spin_out),
      .agree_cnt  (agree_cnt)
`ifdef ISING_ENERGY_EN
      ,
      .energy     (energy)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Oscillator patterns change just after the falling edge, off the sampling edge
   initial begin
      logic [7:0] ph;
      ph = '0;
      osc_in = '0;
      forever begin
         @(negedge clk);
         #2;
         ph = ph + 8'd1;
         case (osc_mode)
            0:       osc_in = {~ph[1], ph[1], ph[1]};
            1:       osc_in = {(ph[1:0] == 2'b00), ph[0], 1'b0};
            default: osc_in = {3{ph[2]}};
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] wflat();
      return {wmodel[2], wmodel[1], wmodel[0]};
   endfunction

   function automatic logic [7:0] exp_energy(input logic [2:0] s);
      int e;
      int j;
      int p;
      e = 0;
      p = 0;
      for (int i = 0; i < 3; i++) begin
         for (int k = i + 1; k < 3; k++) begin
            j = int'(wmodel[p]) - 2;
            e = (s[i] == s[k]) ? (e - j) : (e + j);
            p++;
         end
      end
      return 8'(e);
   endfunction

   task automatic cfg_write(input logic [1:0] a, input logic [2:0] d);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      if (a < 2'd3) wmodel[a] = d;
      @(negedge clk);
      cfg_we = 1'b0;
      chk("cfg_write", weights, wflat());
   endtask

   task automatic run_anneal(input logic [2:0] init, input logic [31:0] rc, input int mode,
                             input bit wr_at_start, input logic [1:0] wa, input logic [2:0] wd,
                             input bit disturb);
      exp_t e;
      int   cyc;
      int   lo;
      int   hi;
      bit   seen;
      e.lat = 1 + 16 + ((rc == 0) ? 1 : int'(rc)) + 64 + 2;
      case (mode)
         0:       begin e.spin = 3'b100; e.agree = {7'd0,  7'd64, 7'd64}; end
         1:       begin e.spin = 3'b010; e.agree = {7'd48, 7'd32, 7'd64}; end
         default: begin e.spin = 3'b000; e.agree = {7'd64, 7'd64, 7'd64}; end
      endcase
      osc_mode = mode;
      repeat (4) @(negedge clk);
      init_spin = init; run_cycles = rc; start = 1'b1;
      if (wr_at_start) begin
         cfg_we = 1'b1; cfg_addr = wa; cfg_wdata = wd;
         wmodel[wa] = wd;
      end
      e.energy = exp_energy(e.spin);
      sb.push_back(e);
      cyc = 1; lo = 0; hi = 0; seen = 1'b0;
      while (!seen && cyc < 2000) begin
         @(negedge clk);
         start = 1'b0; cfg_we = 1'b0;
         cyc++;
         if (cyc == 2) begin
            chk("array_init", array_init, init);
            chk("busy_rise", busy, 1);
            if (wr_at_start) chk("write_with_start", weights, wflat());
         end
         if (disturb && cyc == 41) begin
            chk("busy_mid_run", busy, 1);
            chk("write_in_run_dropped", weights, wflat());
         end
         if (disturb && cyc == 40) begin
            start = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 3'b111;
         end
         if (array_rstn) hi++; else lo++;
         if (done) seen = 1'b1;
      end
      e = sb.pop_front();
      if (!seen) begin
         chk("done_timeout", done, 1);
      end else begin
         chk("latency", cyc, e.lat);
         chk("rstn_low_cycles", lo, 16);
         chk("rstn_high_cycles", hi, e.lat - 17);
         chk("spin_out", spin_out, e.spin);
         chk("agree_cnt", agree_cnt, e.agree);
         @(negedge clk);
         chk("done_pulse_width", done, 0);
         chk("busy_fall", busy, 0);
         chk("rstn_after_done", array_rstn, 0);
`ifdef ISING_ENERGY_EN
         chk("energy", energy, e.energy);
`endif
         repeat (5) @(negedge clk);
         chk("spin_hold", spin_out, e.spin);
         chk("agree_hold", agree_cnt, e.agree);
      end
   endtask

   task automatic abort_run();
      int pulses;
      @(negedge clk);
      init_spin = 3'b011; run_cycles = 32'd200; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (40) @(negedge clk);
      chk("abort_busy_pre", busy, 1);
      chk("abort_rstn_pre", array_rstn, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) wmodel[i] = 3'b010;
      chk("abort_busy", busy, 0);
      chk("abort_rstn", array_rstn, 0);
      chk("abort_done", done, 0);
      chk("abort_spin_clear", spin_out, 0);
      chk("abort_agree_clear", agree_cnt, 0);
      chk("abort_weights", weights, wflat());
      pulses = 0;
      repeat (300) begin
         @(negedge clk);
         if (done || busy) pulses++;
      end
      chk("no_done_after_abort", pulses, 0);
   endtask

   initial begin
      n_checks = 0; n_err = 0;
      rst = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      init_spin = '0; run_cycles = '0; osc_mode = 0;
      for (int i = 0; i < 3; i++) wmodel[i] = 3'b010;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_weights", weights, 9'b010010010);
      chk("rst_rstn", array_rstn, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_spin", spin_out, 0);
      chk("rst_agree", agree_cnt, 0);
      chk("rst_init", array_init, 0);

      cfg_write(2'd0, 3'b100);
      cfg_write(2'd2, 3'b000);
      cfg_write(2'd3, 3'b111);
      chk("weights_after_cfg", weights, 9'b000010100);

      run_anneal(3'b101, 32'd100, 0, 1'b0, 2'd0, 3'b000, 1'b0);
      run_anneal(3'b010, 32'd0, 1, 1'b1, 2'd1, 3'b110, 1'b0);
      abort_run();
      cfg_write(2'd0, 3'b101);
      run_anneal(3'b111, 32'd50, 2, 1'b0, 2'd0, 3'b000, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
